// File: rtl/svm_phase_sequencer.sv
// Step/direction sequencer and current scheduler for the two-phase space vector modulator.
// Turns step edges into phase_ct moves and schedules the amplitude through off/run/ramp/hold.
module svm_phase_sequencer #(
  parameter int unsigned phase_ct_bits = 8,
  parameter int unsigned timeout_bits  = 24
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     step,
  input  logic                     dir,
  input  logic [2:0]               microstep_shift,
  input  logic [7:0]               run_current,
  input  logic [7:0]               hold_current,
  input  logic [timeout_bits-1:0]  idle_timeout,
  input  logic [7:0]               ramp_div,
  output logic [phase_ct_bits-1:0] phase_ct,
  output logic [7:0]               current,
  output logic [1:0]               state,
  output logic                     step_dropped
);

  localparam int unsigned MaxShift = phase_ct_bits - 2;
  localparam logic [phase_ct_bits-1:0] PhaseOne = phase_ct_bits'(1);

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StRun  = 2'd1,
    StRamp = 2'd2,
    StHold = 2'd3
  } state_e;

  state_e                   state_q;
  logic                     step_q;
  logic                     dropped_q;
  logic [phase_ct_bits-1:0] phase_q;
  logic [7:0]               current_q;
  logic [timeout_bits-1:0]  timeout_q;
  logic [7:0]               div_q;

  logic                     step_edge;
  logic [31:0]              shift_eff;
  logic [phase_ct_bits-1:0] phase_inc;
  logic [phase_ct_bits-1:0] phase_next;
  logic                     timeout_hit;
  logic                     above_hold1;

  always_comb begin
    step_edge   = step & ~step_q;
    shift_eff   = (32'(microstep_shift) > MaxShift) ? MaxShift : 32'(microstep_shift);
    phase_inc   = PhaseOne << (MaxShift - shift_eff);
    phase_next  = dir ? (phase_q + phase_inc) : (phase_q - phase_inc);
    timeout_hit = (idle_timeout != '0) && (timeout_q == (idle_timeout - timeout_bits'(1)));
    // 9-bit compare so hold_current = 255 cannot wrap.
    above_hold1 = {1'b0, current_q} > ({1'b0, hold_current} + 9'd1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StOff;
      step_q    <= 1'b0;
      dropped_q <= 1'b0;
      phase_q   <= '0;
      current_q <= '0;
      timeout_q <= '0;
      div_q     <= '0;
    end else begin
      step_q    <= step;
      dropped_q <= 1'b0;
      if (!enable) begin
        // Disable wins over a simultaneous step edge, which is dropped.
        state_q   <= StOff;
        current_q <= '0;
        dropped_q <= step_edge;
      end else if (state_q == StOff) begin
        state_q   <= StRun;
        current_q <= run_current;
        timeout_q <= '0;
        div_q     <= '0;
        dropped_q <= step_edge;
      end else if (step_edge) begin
        phase_q   <= phase_next;
        state_q   <= StRun;
        current_q <= run_current;
        timeout_q <= '0;
        div_q     <= '0;
      end else begin
        unique case (state_q)
          StRun: begin
            current_q <= run_current;
            if (timeout_hit) begin
              state_q <= StRamp;
              div_q   <= '0;
            end else begin
              timeout_q <= timeout_q + timeout_bits'(1);
            end
          end
          StRamp: begin
            // Never ramps upward: at or below the hold level, settle on it.
            if (current_q <= hold_current) begin
              current_q <= hold_current;
              state_q   <= StHold;
            end else if (div_q == ramp_div) begin
              div_q <= '0;
              if (above_hold1) begin
                current_q <= current_q - 8'd1;
              end else begin
                current_q <= hold_current;
                state_q   <= StHold;
              end
            end else begin
              div_q <= div_q + 8'd1;
            end
          end
          StHold: current_q <= hold_current;
          default: ;
        endcase
      end
    end
  end

  assign phase_ct     = phase_q;
  assign current      = current_q;
  assign state        = state_q;
  assign step_dropped = dropped_q;

endmodule

// File: tb/tb_svm_phase_sequencer.sv
// Self-checking bench for svm_phase_sequencer: directed scenarios plus a randomized run
// checked against a closed-form model of phase arithmetic and the idle current schedule.
module tb_svm_phase_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        step;
  logic        dir;
  logic [2:0]  microstep_shift;
  logic [7:0]  run_current;
  logic [7:0]  hold_current;
  logic [23:0] idle_timeout;
  logic [7:0]  ramp_div;
  logic [7:0]  phase_ct;
  logic [7:0]  current;
  logic [1:0]  state;
  logic        step_dropped;

  int n_cmp = 0;
  int n_bad = 0;

  svm_phase_sequencer #(
    .phase_ct_bits(8),
    .timeout_bits (24)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .step           (step),
    .dir            (dir),
    .microstep_shift(microstep_shift),
    .run_current    (run_current),
    .hold_current   (hold_current),
    .idle_timeout   (idle_timeout),
    .ramp_div       (ramp_div),
    .phase_ct       (phase_ct),
    .current        (current),
    .state          (state),
    .step_dropped   (step_dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single step edge; on return the bench observes the first cycle after the edge.
  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; step = 1'b0; dir = 1'b0; microstep_shift = 3'd0;
    run_current = 8'd0; hold_current = 8'd0; idle_timeout = 24'd0; ramp_div = 8'd0;
    repeat (3) tick();
    n_cmp++;
    if ({phase_ct, current, state, step_dropped} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset: phase=%0d cur=%0d state=%0d drop=%0b, want all 0",
               phase_ct, current, state, step_dropped);
    end
  endtask

  task automatic test_enable();
    resetn = 1'b1; enable = 1'b1; run_current = 8'd200;
    tick();
    n_cmp++;
    if (state !== 2'd1 || current !== 8'd200 || phase_ct !== 8'd0) begin
      n_bad++;
      $display("FAIL enable: state=%0d cur=%0d phase=%0d, want 1/200/0", state, current, phase_ct);
    end
  endtask

  task automatic test_phase_stepping();
    logic [7:0] want [4];
    want[0] = 8'd64; want[1] = 8'd128; want[2] = 8'd192; want[3] = 8'd0;
    tick();
    microstep_shift = 3'd6; dir = 1'b0;
    pulse_step();
    n_cmp++;
    if (phase_ct !== 8'd255) begin
      n_bad++;
      $display("FAIL phase_wrap_down: got %0d want 255", phase_ct);
    end
    tick();
    dir = 1'b1;
    pulse_step();
    tick();
    microstep_shift = 3'd0;
    for (int i = 0; i < 4; i++) begin
      pulse_step();
      n_cmp++;
      if (phase_ct !== want[i]) begin
        n_bad++;
        $display("FAIL phase_full_step[%0d]: got %0d want %0d", i, phase_ct, want[i]);
      end
      tick();
    end
    microstep_shift = 3'd7;
    pulse_step();
    n_cmp++;
    if (phase_ct !== 8'd1) begin
      n_bad++;
      $display("FAIL phase_shift7: got %0d want 1", phase_ct);
    end
    tick();
  endtask

  task automatic test_ramp();
    idle_timeout = 24'd10; ramp_div = 8'd3; run_current = 8'd20; hold_current = 8'd17;
    pulse_step();
    repeat (9) tick();
    n_cmp++;
    if (state !== 2'd1 || current !== 8'd20) begin
      n_bad++;
      $display("FAIL ramp_pre_timeout: state=%0d cur=%0d want 1/20", state, current);
    end
    tick();
    n_cmp++;
    if (state !== 2'd2 || current !== 8'd20) begin
      n_bad++;
      $display("FAIL ramp_entry: state=%0d cur=%0d want 2/20", state, current);
    end
    repeat (3) tick();
    n_cmp++;
    if (current !== 8'd20) begin
      n_bad++;
      $display("FAIL ramp_no_early_dec: cur=%0d want 20", current);
    end
    tick();
    n_cmp++;
    if (current !== 8'd19 || state !== 2'd2) begin
      n_bad++;
      $display("FAIL ramp_dec1: state=%0d cur=%0d want 2/19", state, current);
    end
    repeat (4) tick();
    n_cmp++;
    if (current !== 8'd18 || state !== 2'd2) begin
      n_bad++;
      $display("FAIL ramp_dec2: state=%0d cur=%0d want 2/18", state, current);
    end
    repeat (4) tick();
    n_cmp++;
    if (current !== 8'd17 || state !== 2'd3) begin
      n_bad++;
      $display("FAIL ramp_hold: state=%0d cur=%0d want 3/17", state, current);
    end
    tick();
  endtask

  task automatic test_step_in_ramp();
    logic [7:0] p0;
    pulse_step();
    repeat (18) tick();
    n_cmp++;
    if (state !== 2'd2 || current !== 8'd18) begin
      n_bad++;
      $display("FAIL sir_setup: state=%0d cur=%0d want 2/18", state, current);
    end
    p0 = phase_ct; dir = 1'b1; microstep_shift = 3'd0;
    pulse_step();
    n_cmp++;
    if (state !== 2'd1 || current !== 8'd20 || phase_ct !== 8'(p0 + 8'd64)) begin
      n_bad++;
      $display("FAIL sir_resume: state=%0d cur=%0d phase=%0d want 1/20/%0d",
               state, current, phase_ct, 8'(p0 + 8'd64));
    end
    repeat (9) tick();
    n_cmp++;
    if (state !== 2'd1) begin
      n_bad++;
      $display("FAIL sir_timeout_restart: state=%0d want 1", state);
    end
    tick();
    n_cmp++;
    if (state !== 2'd2) begin
      n_bad++;
      $display("FAIL sir_ramp_again: state=%0d want 2", state);
    end
  endtask

  task automatic test_hold_above_run();
    run_current = 8'd200; hold_current = 8'd220; idle_timeout = 24'd10;
    pulse_step();
    repeat (10) tick();
    n_cmp++;
    if (state !== 2'd2 || current !== 8'd200) begin
      n_bad++;
      $display("FAIL hold_above_ramp: state=%0d cur=%0d want 2/200", state, current);
    end
    tick();
    n_cmp++;
    if (state !== 2'd3 || current !== 8'd220) begin
      n_bad++;
      $display("FAIL hold_above_hold: state=%0d cur=%0d want 3/220", state, current);
    end
    tick();
  endtask

  task automatic test_no_timeout();
    int bad_cycles = 0;
    idle_timeout = 24'd0;
    pulse_step();
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (state !== 2'd1 || current !== 8'd200) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL no_timeout: %0d cycles left RUN/200, want 0", bad_cycles);
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] p0;
    p0 = phase_ct;
    enable = 1'b0; step = 1'b1;
    tick();
    n_cmp++;
    if (state !== 2'd0 || current !== 8'd0 || phase_ct !== p0 || step_dropped !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_same_cycle: state=%0d cur=%0d phase=%0d drop=%0b want 0/0/%0d/1",
               state, current, phase_ct, step_dropped, p0);
    end
    tick();
    n_cmp++;
    if (step_dropped !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_one_cycle: drop=%0b want 0", step_dropped);
    end
    step = 1'b0;
    tick();
    pulse_step();
    n_cmp++;
    if (step_dropped !== 1'b1 || phase_ct !== p0 || state !== 2'd0) begin
      n_bad++;
      $display("FAIL drop_in_off: drop=%0b phase=%0d state=%0d want 1/%0d/0",
               step_dropped, phase_ct, state, p0);
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if (state !== 2'd1 || current !== run_current) begin
      n_bad++;
      $display("FAIL reenable: state=%0d cur=%0d want 1/%0d", state, current, run_current);
    end
  endtask

  task automatic test_reset_mid_ramp();
    run_current = 8'd20; hold_current = 8'd17; idle_timeout = 24'd10; ramp_div = 8'd3;
    tick();
    pulse_step();
    repeat (12) tick();
    n_cmp++;
    if (state !== 2'd2) begin
      n_bad++;
      $display("FAIL rst_mid_setup: state=%0d want 2", state);
    end
    resetn = 1'b0;
    tick();
    n_cmp++;
    if ({phase_ct, current, state, step_dropped} !== 19'd0) begin
      n_bad++;
      $display("FAIL rst_mid_ramp: phase=%0d cur=%0d state=%0d drop=%0b want all 0",
               phase_ct, current, state, step_dropped);
    end
    resetn = 1'b1;
  endtask

  // Model: phase is modular arithmetic; current follows from the age since the last RUN entry.
  task automatic test_random();
    int         age, p, k, d, inc, sh;
    bit         off, step_prev, edge_seen;
    logic [7:0] e_phase, e_cur;
    logic [1:0] e_state;
    logic       e_drop;
    int         run_i, hold_i, t_i, div_i;
    run_current  = 8'($urandom_range(1, 255));
    hold_current = 8'($urandom_range(0, 255));
    ramp_div     = 8'($urandom_range(0, 3));
    idle_timeout = 24'($urandom_range(1, 20));
    run_i = run_current; hold_i = hold_current; t_i = idle_timeout; div_i = ramp_div;
    resetn = 1'b0; step = 1'b0; enable = 1'b0;
    tick();
    resetn = 1'b1;
    off = 1'b1; step_prev = 1'b0; age = 0; e_phase = 8'd0; p = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) p = $urandom_range(0, 3) * 10;
      enable          = ($urandom_range(0, 99) != 0);
      step            = (p != 0) && ($urandom_range(1, p) <= 3);
      dir             = 1'($urandom_range(0, 1));
      microstep_shift = 3'($urandom_range(0, 7));
      tick();
      edge_seen = step && !step_prev;
      step_prev = step;
      e_drop = 1'b0;
      if (!enable) begin
        off = 1'b1; e_drop = edge_seen;
      end else if (off) begin
        off = 1'b0; age = 0; e_drop = edge_seen;
      end else if (edge_seen) begin
        sh  = (microstep_shift > 6) ? 6 : int'(microstep_shift);
        inc = 1 << (6 - sh);
        e_phase = 8'((int'(e_phase) + (dir ? inc : 256 - inc)) % 256);
        age = 0;
      end else if (age < 1000000) begin
        age++;
      end
      if (off) begin
        e_state = 2'd0; e_cur = 8'd0;
      end else if (age < t_i) begin
        e_state = 2'd1; e_cur = 8'(run_i);
      end else begin
        k = age - t_i;
        if (run_i <= hold_i) begin
          e_state = (k == 0) ? 2'd2 : 2'd3;
          e_cur   = (k == 0) ? 8'(run_i) : 8'(hold_i);
        end else begin
          d = k / (div_i + 1);
          e_state = (d < run_i - hold_i) ? 2'd2 : 2'd3;
          e_cur   = (d < run_i - hold_i) ? 8'(run_i - d) : 8'(hold_i);
        end
      end
      n_cmp++;
      if ({phase_ct, current, state, step_dropped} !== {e_phase, e_cur, e_state, e_drop}) begin
        n_bad++;
        $display("FAIL random[%0d]: phase=%0d cur=%0d state=%0d drop=%0b want %0d/%0d/%0d/%0b",
                 c, phase_ct, current, state, step_dropped, e_phase, e_cur, e_state, e_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_phase_stepping();
    test_ramp();
    test_step_in_ramp();
    test_hold_above_run();
    test_no_timeout();
    test_enable_drop();
    test_reset_mid_ramp();
    for (int r = 0; r < 4; r++) test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/svm_phase_sequencer.md
# svm_phase_sequencer

Step/direction sequencer and current scheduler for the two-phase space vector modulator. Converts synchronous step/dir commands into the modulator's `phase_ct` (0..2π integer phase) at a programmable microstep resolution. Schedules the vector amplitude (`current`) through off, run, ramp-down and hold phases, so an idle motor drops to a configured holding current. Sits between the motion/command logic and the modulator's `phase_ct` and `current` inputs.

## Interface
- `phase_ct_bits`, 8: width of `phase_ct`; one electrical revolution = 2^phase_ct_bits counts; must be ≥ 3.
- `timeout_bits`, 24: width of the idle timeout counter and its configuration input.
- `clk`  in  1  system clock; same domain as the modulator's `clk`.
- `resetn`  in  1  reset, synchronous, active-low.
- `enable`  in  1  driver enable level.
- `step`  in  1  step request; the rising edge is detected internally.
- `dir`  in  1  direction, sampled in the step-edge cycle: 1 = phase increases, 0 = phase decreases.
- `microstep_shift`  in  3  resolution: increment = 2^(phase_ct_bits-2-m), with m = min(microstep_shift, phase_ct_bits-2).
- `run_current`  in  8  amplitude while moving.
- `hold_current`  in  8  amplitude target when idle.
- `idle_timeout`  in  timeout_bits  number of RUN cycles before ramp-down; 0 = never ramp.
- `ramp_div`  in  8  ramp-down rate: one LSB of current per ramp_div+1 cycles.
- `phase_ct`  out  phase_ct_bits  phase to the modulator.
- `current`  out  8  amplitude to the modulator.
- `state`  out  2  OFF=0, RUN=1, RAMP=2, HOLD=3.
- `step_dropped`  out  1  one-cycle pulse when a step edge is ignored because the block is in OFF.

## Operation
- Edge detect: `step_q` registers `step`. An edge is `step & ~step_q`. `step_q` resets to 0, so `step` held high through reset produces one edge in the first cycle after reset.
- Accepted step (edge while not in OFF):
  - `phase_ct` ← `phase_ct` ± increment, modulo 2^phase_ct_bits; wrap-around is silent.
  - State → RUN, `current` ← `run_current`, timeout counter ← 0, ramp divider ← 0.
- State machine:
  - OFF: `current`=0. While `enable`=1 → RUN with `current`←`run_current` and counters cleared. Step edges assert `step_dropped`; `phase_ct` does not change.
  - RUN: `current` tracks `run_current` every cycle. The timeout counter increments each cycle. When `idle_timeout`≠0 and counter = `idle_timeout`-1 with no step edge → RAMP. `idle_timeout`=0 holds RUN indefinitely.
  - RAMP: the ramp divider counts 0..`ramp_div`. On the terminal count:
    - if `current` > `hold_current`+1: `current`←`current`-1;
    - otherwise `current`←`hold_current` and → HOLD.
  - RAMP entry check: if `current` ≤ `hold_current` on entry, the next cycle sets `current`←`hold_current` and → HOLD. This covers `hold_current` ≥ `run_current`; the scheduler never ramps upward.
  - HOLD: `current` tracks `hold_current` every cycle.
- `enable`=0 in any state → OFF next cycle, `current`←0, `phase_ct` retained. This has priority over a simultaneous step edge, which is dropped and flagged.
- Step edge in RAMP or HOLD → RUN immediately; current jumps to `run_current`.
- Configuration inputs may change at any time. `microstep_shift` and `dir` take effect at the next accepted step.

## Timing
- Reset values: `phase_ct`=0, `current`=0, `state`=OFF, `step_dropped`=0; all counters 0; `step_q`=0.
- Reset mid-operation returns every register to its reset value on that edge, regardless of state.
- Step latency: edge in cycle N → new `phase_ct`, `current`=`run_current` and `state`=RUN visible in cycle N+1. The modulator adds its own LUT/PWM latency afterwards.
- Maximum step rate: one accepted step per two cycles (step must return low for at least one cycle).
- Enable latency: `enable` rises in cycle N → RUN in cycle N+1. `enable` falls in cycle N → OFF and `current`=0 in cycle N+1.
- Timeout: first RUN cycle R (counter=0) → first RAMP cycle is R+`idle_timeout`.
- Ramp: the first decrement is visible `ramp_div`+1 cycles after RAMP entry, then one decrement every `ramp_div`+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset with `step` low, then `enable`=1 and `run_current`=200 → cycle+1: `state`=RUN, `current`=200, `phase_ct`=0.
- Phase stepping:
  - `microstep_shift`=6, `dir`=0, one edge from `phase_ct`=0 → `phase_ct`=255 (wrap).
  - `microstep_shift`=0, `dir`=1, four edges → 64, 128, 192, 0.
  - `microstep_shift`=7 behaves as 6 (increment 1).
- Ramp-down: `idle_timeout`=10, `ramp_div`=3, `run_current`=20, `hold_current`=17.
  - RAMP at R+10.
  - `current` = 19, 18, 17 at 4-cycle intervals.
  - HOLD entered on the third decrement.
- Step during RAMP with `current`=18 → next cycle: RUN, `current`=20, `phase_ct` advanced, timeout restarts (next RAMP 10 cycles later).
- Idle behaviour:
  - `hold_current`=220 > `run_current`=200, timeout expires → RAMP for one cycle, then HOLD with `current`=220.
  - `idle_timeout`=0 → RUN persists for 10000 cycles.
- `enable` falls in the same cycle as a step edge → OFF, `current`=0, `phase_ct` unchanged, `step_dropped` pulses for one cycle. Assert `resetn`=0 mid-RAMP → all outputs reach their reset values on the next edge.
